// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The adder takes the slave side; a requester/consumer pair takes the master side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder and one carry flop, LSB first,
// one bit per clock, wrapped in an IDLE/RUN/DONE valid-ready controller.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic faA;
    logic faB;
    logic faSum;
    logic faCarry;

    // The single full adder shared by every bit position.
    assign faA     = opA_q[cnt_q];
    assign faB     = opB_q[cnt_q];
    assign faSum   = faA ^ faB ^ carry_q;
    assign faCarry = (faA & faB) | (carry_q & (faA ^ faB));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // Subtraction is a + ~b + 1, so invert b and force the carry-in.
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    opA_d   = bus.a;
                    opB_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                sum_d[cnt_q] = faSum;
                carry_d      = faCarry;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    cout_d  = faCarry;
                    ovf_d   = carry_q ^ faCarry;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=3: directed corner cases plus
// random traffic scored against an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W0     = 8;
    localparam int W1     = 3;
    localparam int NPAIRS = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        drvValid[2];
    logic        drvCin[2];
    logic        drvSub[2];
    logic        drvOutReady[2];
    logic [31:0] drvA[2];
    logic [31:0] drvB[2];

    logic        obsValid[2];
    logic        obsInReady[2];
    logic        obsBusy[2];
    logic        obsCout[2];
    logic        obsOv[2];
    logic [31:0] obsSum[2];

    serial_add_ctrl_if #(.WIDTH(W0)) bus0 ();
    serial_add_ctrl_if #(.WIDTH(W1)) bus1 ();

    serial_add_ctrl #(.WIDTH(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_add_ctrl #(.WIDTH(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.in_valid  = drvValid[0];
    assign bus0.a         = drvA[0][W0-1:0];
    assign bus0.b         = drvB[0][W0-1:0];
    assign bus0.cin       = drvCin[0];
    assign bus0.sub       = drvSub[0];
    assign bus0.out_ready = drvOutReady[0];
    assign bus1.in_valid  = drvValid[1];
    assign bus1.a         = drvA[1][W1-1:0];
    assign bus1.b         = drvB[1][W1-1:0];
    assign bus1.cin       = drvCin[1];
    assign bus1.sub       = drvSub[1];
    assign bus1.out_ready = drvOutReady[1];

    assign obsValid[0]   = bus0.out_valid;
    assign obsInReady[0] = bus0.in_ready;
    assign obsBusy[0]    = bus0.busy;
    assign obsCout[0]    = bus0.cout;
    assign obsOv[0]      = bus0.overflow;
    assign obsSum[0]     = 32'(bus0.sum);
    assign obsValid[1]   = bus1.out_valid;
    assign obsInReady[1] = bus1.in_ready;
    assign obsBusy[1]    = bus1.busy;
    assign obsCout[1]    = bus1.cout;
    assign obsOv[1]      = bus1.overflow;
    assign obsSum[1]     = 32'(bus1.sum);

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
        int          accCyc;
    } expT;

    expT expQ[2][$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  accCount[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wOf(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    // Reference model: plain signed/unsigned integer arithmetic on the operands.
    function automatic expT mkExp(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input int accCyc);
        longint modv;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint full;
        longint sres;
        expT    r;
        modv = longint'(1) << w;
        ua   = longint'(a) & (modv - 1);
        ub   = longint'(b) & (modv - 1);
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        if (sub) begin
            full   = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            full   = ua + ub + longint'(cin);
            sres   = sa + sb + longint'(cin);
            r.cout = (full >= modv);
        end
        r.sum    = 32'(full & (modv - 1));
        r.ov     = (sres >= modv / 2) || (sres < -(modv / 2));
        r.accCyc = accCyc;
        return r;
    endfunction

    function automatic bit resultDue(input int k);
        if (expQ[k].size() == 0) return 1'b0;
        return cyc >= expQ[k][0].accCyc + 1 + wOf(k);
    endfunction

    task automatic checkValue(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL dut%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", k, name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: checks handshake state every cycle, compares results, records accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                checkValue("in_ready", k, 32'(obsInReady[k]), 32'(expQ[k].size() == 0));
                checkValue("busy", k, 32'(obsBusy[k]), 32'(expQ[k].size() != 0));
                checkValue("out_valid", k, 32'(obsValid[k]), 32'(resultDue(k)));
                if (resultDue(k)) begin
                    checkValue("sum", k, obsSum[k], expQ[k][0].sum);
                    checkValue("cout", k, 32'(obsCout[k]), 32'(expQ[k][0].cout));
                    checkValue("overflow", k, 32'(obsOv[k]), 32'(expQ[k][0].ov));
                    if (drvOutReady[k]) void'(expQ[k].pop_front());
                end
                if (drvValid[k] && obsInReady[k]) begin
                    expQ[k].push_back(mkExp(wOf(k), drvA[k], drvB[k], drvCin[k], drvSub[k], cyc));
                    accCount[k] <= accCount[k] + 1;
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, output int accCyc);
        bit taken;
        taken       = 1'b0;
        accCyc      = -1;
        drvA[k]     = a;
        drvB[k]     = b;
        drvCin[k]   = cin;
        drvSub[k]   = sub;
        drvValid[k] = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (obsInReady[k]) begin
                taken  = 1'b1;
                accCyc = cyc;
            end
        end
        if (!taken) checkValue("accept_timeout", k, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drvValid[k] = 1'b0;
    endtask

    task automatic checkOutput(input int k, input logic [31:0] s, input logic co, input logic ov,
                               input int accCyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (obsValid[k]) seen = 1'b1;
        end
        checkValue("result_seen", k, 32'(seen), 32'd1);
        checkValue("latency", k, 32'(cyc - accCyc - 1), 32'(wOf(k)));
        checkValue("d_sum", k, obsSum[k], s);
        checkValue("d_cout", k, 32'(obsCout[k]), 32'(co));
        checkValue("d_overflow", k, 32'(obsOv[k]), 32'(ov));
    endtask

    task automatic checkResetState();
        checkValue("rst_sum", 0, obsSum[0], 32'd0);
        checkValue("rst_cout", 0, 32'(obsCout[0]), 32'd0);
        checkValue("rst_overflow", 0, 32'(obsOv[0]), 32'd0);
        checkValue("rst_out_valid", 0, 32'(obsValid[0]), 32'd0);
        checkValue("rst_busy", 0, 32'(obsBusy[0]), 32'd0);
        checkValue("rst_in_ready", 0, 32'(obsInReady[0]), 32'd1);
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [31:0] s, input logic co, input logic ov);
        int acc;
        applyStimulus(0, a, b, cin, sub, acc);
        checkOutput(0, s, co, ov, acc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int target[2];
        bit drained;
        for (int k = 0; k < 2; k++) begin
            drvValid[k]    = 1'b0;
            drvA[k]        = '0;
            drvB[k]        = '0;
            drvCin[k]      = 1'b0;
            drvSub[k]      = 1'b0;
            drvOutReady[k] = 1'b1;
        end
        #1;
        checkResetState();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed(32'h0F, 32'h01, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0);
        directed(32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
        directed(32'hFF, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        directed(32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0);
        directed(32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1);

        // Consumer stalls for five cycles while the requester pushes new operands.
        drvOutReady[0] = 1'b0;
        applyStimulus(0, 32'h12, 32'h34, 1'b0, 1'b0, acc);
        checkOutput(0, 32'h46, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            drvValid[0] = 1'b1;
            drvA[0]     = $urandom;
            drvB[0]     = $urandom;
            drvSub[0]   = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkValue("hold_valid", 0, 32'(obsValid[0]), 32'd1);
            checkValue("hold_sum", 0, obsSum[0], 32'h46);
            checkValue("hold_in_ready", 0, 32'(obsInReady[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        drvValid[0]    = 1'b0;
        drvOutReady[0] = 1'b1;
        @(posedge clk);
        #1;
        checkValue("release_in_ready", 0, 32'(obsInReady[0]), 32'd1);
        checkValue("release_out_valid", 0, 32'(obsValid[0]), 32'd0);

        // Abort mid-operation with bit counter at 3.
        applyStimulus(0, 32'hAA, 32'h55, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expQ[0].delete();
        expQ[1].delete();
        #1;
        checkResetState();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed(32'h01, 32'h01, 1'b0, 1'b0, 32'h02, 1'b0, 1'b0);

        // Random traffic on both widths with random valid and ready gaps.
        target[0] = accCount[0] + NPAIRS;
        target[1] = accCount[1] + NPAIRS;
        for (int c = 0; c < 60000 && !(accCount[0] >= target[0] && accCount[1] >= target[1]); c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                drvValid[k]    = (accCount[k] < target[k]) && ($urandom_range(0, 3) != 0);
                drvA[k]        = $urandom;
                drvB[k]        = $urandom;
                drvCin[k]      = 1'($urandom_range(0, 1));
                drvSub[k]      = 1'($urandom_range(0, 1));
                drvOutReady[k] = ($urandom_range(0, 2) != 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            drvValid[k]    = 1'b0;
            drvOutReady[k] = 1'b1;
        end
        drained = 1'b0;
        for (int i = 0; i < 200 && !drained; i++) begin
            @(negedge clk);
            drained = (expQ[0].size() == 0) && (expQ[1].size() == 0);
        end
        for (int k = 0; k < 2; k++) begin
            checkValue("pairs_accepted", k, 32'(accCount[k] >= target[k]), 32'd1);
            checkValue("queue_drained", k, 32'(expQ[k].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
